// File: rtl/line_buffer_pkg.sv
// Shared sizing, FSM state type and read-mask helper for the line-buffer controller.
// Declarations only: no state, no timing, no flow control.
package line_buffer_pkg;

  localparam int LB_COUNT    = 4;
  localparam int KERNEL_ROWS = 3;
  localparam int FILL_W      = 12;

  localparam logic [LB_COUNT-1:0] KERNEL_MASK0 = LB_COUNT'((1 << KERNEL_ROWS) - 1);

  typedef logic [1:0] lb_sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } rd_state_t;

  // Rotate the base three-row mask so that bit `base` is the top row.
  function automatic logic [LB_COUNT-1:0] kernel_mask(input lb_sel_t base);
    logic [2*LB_COUNT-1:0] ext;
    ext = {{LB_COUNT{1'b0}}, KERNEL_MASK0} << base;
    return ext[LB_COUNT-1:0] | ext[2*LB_COUNT-1:LB_COUNT];
  endfunction

endpackage

// File: rtl/lb_window_mux.sv
// Picks three of the four line-buffer outputs as top/middle/bottom window rows.
// Purely combinational, zero latency; no flow control of its own.
module lb_window_mux
  import line_buffer_pkg::*;
#(
  parameter int ROW_W = 24
) (
  input  logic [1:0]         rd_sel,
  input  logic [ROW_W-1:0]   lb_data0,
  input  logic [ROW_W-1:0]   lb_data1,
  input  logic [ROW_W-1:0]   lb_data2,
  input  logic [ROW_W-1:0]   lb_data3,
  output logic [3*ROW_W-1:0] window_out
);

  logic [ROW_W-1:0] rows [LB_COUNT];
  lb_sel_t          mid_sel;
  lb_sel_t          bot_sel;

  assign rows[0] = lb_data0;
  assign rows[1] = lb_data1;
  assign rows[2] = lb_data2;
  assign rows[3] = lb_data3;

  always_comb begin
    mid_sel    = rd_sel + 2'd1;
    bot_sel    = rd_sel + 2'd2;
    window_out = {rows[rd_sel], rows[mid_sel], rows[bot_sel]};
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Round-robin line-buffer write steering plus lock-step 3-line read sequencing for a 3x3 kernel.
// Write enables are same-cycle; READ starts one edge after 3 lines are held; in_ready drops when all 4 slots are full.
module line_buffer_ctrl
  import line_buffer_pkg::*;
#(
  parameter int LINE_WIDTH = 512,
  parameter int PIXEL_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_W-1:0]    pixel_in,
  input  logic                  pixel_in_valid,
  output logic                  in_ready,
  output logic [LB_COUNT-1:0]   lb_input_valid,
  output logic [LB_COUNT-1:0]   lb_read_data,
  input  logic [3*PIXEL_W-1:0]  lb_data0,
  input  logic [3*PIXEL_W-1:0]  lb_data1,
  input  logic [3*PIXEL_W-1:0]  lb_data2,
  input  logic [3*PIXEL_W-1:0]  lb_data3,
  output logic [9*PIXEL_W-1:0]  window_out,
  output logic                  window_valid,
  output logic                  intr
);

  localparam int                CNT_W       = $clog2(LINE_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(LINE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [FILL_W-1:0] FILL_ONE    = FILL_W'(1);
  localparam logic [FILL_W-1:0] FILL_LINE   = FILL_W'(LINE_WIDTH);
  localparam logic [FILL_W-1:0] FILL_KERNEL = FILL_W'(KERNEL_ROWS * LINE_WIDTH);
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(LB_COUNT * LINE_WIDTH);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  lb_sel_t           wr_sel;
  lb_sel_t           rd_sel;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              accept;
  logic              wr_last;
  logic              rd_last;

  // Pixel data bypasses the controller: the line buffers tap pixel_in directly.
  logic pixel_unused;
  assign pixel_unused = ^pixel_in;

  assign in_ready       = (fill != FILL_FULL);
  assign accept         = pixel_in_valid && in_ready;
  assign wr_last        = accept && (wr_cnt == CNT_LAST);
  assign rd_last        = (state == ST_READ) && (rd_cnt == CNT_LAST);
  assign lb_input_valid = {{(LB_COUNT-1){1'b0}}, accept} << wr_sel;

  always_comb begin
    fill_nxt = fill;
    if (accept) begin
      fill_nxt = fill_nxt + FILL_ONE;
    end
    if (rd_last) begin
      fill_nxt = fill_nxt - FILL_LINE;
    end
  end

  // IDLE looks at the post-edge fill so READ starts right after the third line lands.
  always_comb begin
    state_nxt    = state;
    lb_read_data = '0;
    window_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fill_nxt >= FILL_KERNEL) begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        lb_read_data = kernel_mask(rd_sel);
        window_valid = 1'b1;
        if (rd_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_sel <= '0;
      rd_sel <= '0;
      fill   <= '0;
      intr   <= 1'b0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
      intr  <= rd_last;
      if (accept) begin
        if (wr_last) begin
          wr_cnt <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_cnt <= wr_cnt + CNT_ONE;
        end
      end
      if (state == ST_READ) begin
        if (rd_last) begin
          rd_cnt <= '0;
          rd_sel <= rd_sel + 2'd1;
        end else begin
          rd_cnt <= rd_cnt + CNT_ONE;
        end
      end
    end
  end

  lb_window_mux #(
    .ROW_W (3*PIXEL_W)
  ) u_window_mux (
    .rd_sel     (rd_sel),
    .lb_data0   (lb_data0),
    .lb_data1   (lb_data1),
    .lb_data2   (lb_data2),
    .lb_data3   (lb_data3),
    .window_out (window_out)
  );

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl with a behavioural model of the four external line buffers.
module tb_line_buffer_ctrl;

  localparam int LW = 512;

  logic        clk;
  logic        rst;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic        in_ready;
  logic [3:0]  lb_input_valid;
  logic [3:0]  lb_read_data;
  logic [23:0] lb_data0, lb_data1, lb_data2, lb_data3;
  logic [71:0] window_out;
  logic        window_valid;
  logic        intr;

  line_buffer_ctrl #(.LINE_WIDTH(LW), .PIXEL_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_in       (pixel_in),
    .pixel_in_valid (pixel_in_valid),
    .in_ready       (in_ready),
    .lb_input_valid (lb_input_valid),
    .lb_read_data   (lb_read_data),
    .lb_data0       (lb_data0),
    .lb_data1       (lb_data1),
    .lb_data2       (lb_data2),
    .lb_data3       (lb_data3),
    .window_out     (window_out),
    .window_valid   (window_valid),
    .intr           (intr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External line buffers: write at wp on enable, present 3 pixels from rp, advance rp on read strobe.
  logic [7:0]  lb_mem [4][LW];
  logic [8:0]  lb_wp  [4];
  logic [8:0]  lb_rp  [4];
  logic [23:0] lb_dat [4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        lb_wp[i] <= '0;
        lb_rp[i] <= '0;
      end else begin
        if (lb_input_valid[i]) begin
          lb_mem[i][lb_wp[i]] <= pixel_in;
          lb_wp[i] <= lb_wp[i] + 9'd1;
        end
        if (lb_read_data[i]) lb_rp[i] <= lb_rp[i] + 9'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lb_dat[i] = {lb_mem[i][lb_rp[i]], lb_mem[i][lb_rp[i] + 9'd1], lb_mem[i][lb_rp[i] + 9'd2]};
    end
  end

  assign lb_data0 = lb_dat[0];
  assign lb_data1 = lb_dat[1];
  assign lb_data2 = lb_dat[2];
  assign lb_data3 = lb_dat[3];

  typedef struct packed {
    logic [3:0]  mask;
    logic [71:0] win;
    logic        care;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   stalls = 0;
  int   wline  = 0;
  int   wcol   = 0;
  bit   exp_intr = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int l, input int c);
    int v;
    v = (c + l * 37) % 256;
    return v[7:0];
  endfunction

  function automatic logic [23:0] row(input int l, input int k);
    return {pix(l, k), pix(l, (k + 1) % LW), pix(l, (k + 2) % LW)};
  endfunction

  // Read r uses lines r, r+1, r+2 held in buffers r%4, (r+1)%4, (r+2)%4.
  task automatic push_read(input int r);
    exp_t e;
    for (int k = 0; k < LW; k++) begin
      e.mask = 4'b0;
      e.mask[r % 4]       = 1'b1;
      e.mask[(r + 1) % 4] = 1'b1;
      e.mask[(r + 2) % 4] = 1'b1;
      e.win  = {row(r, k), row(r + 1, k), row(r + 2, k)};
      e.care = (k < LW - 2);
      e.last = (k == LW - 1);
      q.push_back(e);
    end
  endtask

  // Offer one pixel, retrying while in_ready is low; returns #1 after the accepting edge.
  task automatic send_pixel();
    int   tries;
    bit   done;
    logic [3:0] exp_v;
    tries = 0;
    done  = 1'b0;
    pixel_in       = pix(wline, wcol);
    pixel_in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        stalls++;
        chk("drop_no_write", lb_input_valid, 4'b0000);
        chk("full_fill", dut.fill, 12'd2048);
        tries++;
        if (tries > 2000) begin
          $display("FAIL send_timeout: in_ready stuck low, line %0d col %0d", wline, wcol);
          $fatal(1);
        end
        @(posedge clk);
        #1;
      end
    end
    exp_v = 4'b0001 << (wline % 4);
    chk("wr_enable", lb_input_valid, exp_v);
    @(posedge clk);
    #1;
    if (wcol == LW - 1) begin
      if (wline >= 2) push_read(wline - 2);
      wline++;
      wcol = 0;
    end else begin
      wcol++;
    end
  endtask

  task automatic idle_cycles(input int n);
    pixel_in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int c;
    c = 0;
    pixel_in_valid = 1'b0;
    while ((q.size() != 0 || window_valid) && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (c >= max_cycles) begin
      errors++;
      $display("FAIL %s: timeout, %0d windows still expected, required 0", name, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected window per valid cycle and checks the intr pulse that follows a read.
  always @(negedge clk) begin
    exp_t e;
    bit   nxt_intr;
    nxt_intr = 1'b0;
    if (intr === 1'b1 || exp_intr) chk("intr", intr, exp_intr);
    if (window_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: lb_read_data=%b, required no window", lb_read_data);
      end else begin
        e = q.pop_front();
        chk("rd_mask", lb_read_data, e.mask);
        if (e.care) chk("window", window_out, e.win);
        nxt_intr = e.last;
      end
    end else if (lb_read_data != 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL idle_read_strobe: lb_read_data=%b, required 0000", lb_read_data);
    end
    exp_intr = nxt_intr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst            = 1'b1;
    pixel_in       = 8'h00;
    pixel_in_valid = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(4);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_lb_input_valid", lb_input_valid, 4'b0000);
    chk("rst_lb_read_data", lb_read_data, 4'b0000);
    chk("rst_window_valid", window_valid, 1'b0);
    chk("rst_intr", intr, 1'b0);
    chk("rst_fill", dut.fill, 12'd0);
    @(posedge clk);
    #1;

    // First kernel: lines 0..2
    for (int i = 0; i < 3 * LW; i++) send_pixel();
    pixel_in_valid = 1'b0;
    @(negedge clk);
    chk("read_start", window_valid, 1'b1);
    chk("first_mask", lb_read_data, 4'b0111);
    chk("first_window", window_out, 72'h000102_252627_4a4b4c);
    n = 1;
    for (int c = 0; c < 600 && window_valid; c++) begin
      @(negedge clk);
      if (window_valid) n++;
    end
    chk("read_len", n, 512);
    chk("intr_after_read", intr, 1'b1);
    chk("fill_after_read", dut.fill, 12'd1024);
    @(negedge clk);
    chk("intr_one_cycle", intr, 1'b0);
    @(posedge clk);
    #1;

    // Rotation with back-pressure: lines 3..8 streamed continuously
    stalls = 0;
    for (int i = 0; i < 6 * LW; i++) send_pixel();
    wait_drain(3000, "rotation_drain");
    chk("stall_count", stalls, 3);
    chk("fill_after_rotation", dut.fill, 12'd1024);

    // Simultaneous accept and line completion
    for (int i = 0; i < LW + 264; i++) send_pixel();
    idle_cycles(247);
    chk("fill_pre_sim", dut.fill, 12'd1800);
    send_pixel();
    pixel_in_valid = 1'b0;
    chk("fill_sim", dut.fill, 12'd1289);
    @(negedge clk);
    chk("read_end_sim", window_valid, 1'b0);
    @(posedge clk);
    #1;

    // Reset in the middle of a READ
    for (int i = 0; i < LW - 265; i++) send_pixel();
    idle_cycles(200);
    chk("rd_cnt_200", dut.rd_cnt, 9'd200);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    wline = 0;
    wcol  = 0;
    chk("mid_rst_read_data", lb_read_data, 4'b0000);
    chk("mid_rst_window_valid", window_valid, 1'b0);
    chk("mid_rst_fill", dut.fill, 12'd0);
    chk("mid_rst_rd_sel", dut.rd_sel, 2'd0);
    chk("mid_rst_intr", intr, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_intr_next", intr, 1'b0);
    rst = 1'b0;
    idle_cycles(2);

    // Restart after reset: first read must again use buffers 0..2
    for (int i = 0; i < 3 * LW; i++) send_pixel();
    wait_drain(1000, "restart_drain");
    chk("fill_final", dut.fill, 12'd1024);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
